parity_frame_tx: RTL

- Serial transmitter that produces the bit stream the team's parity-checking receivers consume.
- On a rising edge of `start`, latches a parallel data word and shifts it out LSB-first on a single line.
- The frame is a start bit, the data bits, a generated even/odd parity bit, then a stop bit.
- Each bit is held for a programmable number of `clk_100Mhz` cycles, so the same block drives board LEDs at slow rates or a link at fast rates.

---
 rtl/parity_frame_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/parity_frame_tx.sv
// parity_frame_tx
//
// Serial frame transmitter. On a rising edge of `start` while idle it latches a
// parallel word and sends it LSB-first on a single idle-high line as:
//   start bit (0) | DATA_W data bits | parity bit | stop bit (1)
// Every bit is held for TICK_DIV clock cycles.
//
// Parameters:
//   DATA_W    data bits per frame (>= 1)
//   TICK_DIV  clk_100Mhz cycles per transmitted bit (>= 2)
//
// Ports:
//   clk_100Mhz  in   system clock, all state on its rising edge
//   reset       in   synchronous, active-high reset
//   start       in   request level (already synchronized); rising edge starts a frame
//   data        in   word to send, sampled only at frame accept
//   parity_sel  in   0 = even parity, 1 = odd parity, sampled only at frame accept
//   tx_out      out  registered serial line, idle high
//   busy        out  high from frame accept through the last stop-bit cycle
//   done        out  one-cycle pulse in the first idle cycle after a frame
//   parity_bit  out  parity of the current/last frame, held until the next accept

module parity_frame_tx #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TICK_DIV = 10000000
) (
  input  logic              clk_100Mhz,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              parity_sel,
  output logic              tx_out,
  output logic              busy,
  output logic              done,
  output logic              parity_bit
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e              state_q, state_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                start_q;
  logic                parity_d;
  logic                tx_d;
  logic                busy_d;
  logic                done_d;
  logic                accept;
  logic                bit_end;

  // Next-state logic. Outputs are derived from the next state so that tx_out and
  // busy are registered yet already reflect the start bit in the cycle after accept.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_bit;
    done_d   = 1'b0;

    accept  = (state_q == StIdle) & start & ~start_q;
    bit_end = (tick_q == TickLast);

    // The bit-period counter only runs while a frame is in flight and wraps at
    // every bit boundary, so it is already zero when the frame returns to idle.
    if (state_q != StIdle) begin
      tick_d = bit_end ? '0 : tick_q + TickW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d  = data;
          parity_d = (^data) ^ parity_sel;
          tick_d   = '0;
          bit_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BitW'(1);
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);

    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      // Held at 1 so a start level present across reset release is not an edge.
      start_q    <= 1'b1;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      start_q    <= start;
      tx_out     <= tx_d;
      busy       <= busy_d;
      done       <= done_d;
      parity_bit <= parity_d;
    end
  end

endmodule
